// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate instruction issue.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle writeback release source and full stalls.
module register_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               issue_valid,
   input  logic               issue_wen,
   input  logic [4:0]         issue_wsel,
   input  logic [4:0]         issue_rsel1,
   input  logic [4:0]         issue_rsel2,
   output logic               issue_stall,
   input  logic               wb_valid,
   input  logic [4:0]         wb_wsel,
   input  logic               flush,
   output logic [31:0]        busy,
   output logic [CNT_W+4:0]   outstanding,
   output logic               wb_err
);

   localparam logic [CNT_W-1:0] MAXP = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q  [1:31];
   logic [CNT_W-1:0] cnt_d  [1:31];
   logic [CNT_W-1:0] cnt_rd [0:31];
   logic [31:0]      busy_q, busy_d;
   logic [CNT_W+4:0] outstanding_q, outstanding_d;
   logic             wb_err_q, wb_err_d;

   logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_w, cnt_wb;
   logic             src1_busy, src2_busy, dst_full;
   logic             accept, inc_en, dec_en;

   // Register 0 is never tracked; its read view is hard-wired to zero.
   assign cnt_rd[0] = '0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_rd
         assign cnt_rd[gi] = cnt_q[gi];
      end
   endgenerate

   assign cnt_r1 = cnt_rd[issue_rsel1];
   assign cnt_r2 = cnt_rd[issue_rsel2];
   assign cnt_w  = cnt_rd[issue_wsel];
   assign cnt_wb = cnt_rd[wb_wsel];

`ifdef SCOREBOARD_BYPASS_EN
   // A writeback retiring the last pending write releases the dependent source this cycle.
   assign src1_busy = (cnt_r1 != '0) && !(wb_valid && (wb_wsel == issue_rsel1) && (cnt_r1 == ONE));
   assign src2_busy = (cnt_r2 != '0) && !(wb_valid && (wb_wsel == issue_rsel2) && (cnt_r2 == ONE));
   assign dst_full  = issue_wen && (issue_wsel != 5'd0) && (cnt_w == MAXP)
                      && !(wb_valid && (wb_wsel == issue_wsel));
`else
   assign src1_busy = (cnt_r1 != '0);
   assign src2_busy = (cnt_r2 != '0);
   assign dst_full  = issue_wen && (issue_wsel != 5'd0) && (cnt_w == MAXP);
`endif

   assign issue_stall = issue_valid && (src1_busy || src2_busy || dst_full);
   assign accept      = issue_valid && !issue_stall;
   assign inc_en      = accept && issue_wen && (issue_wsel != 5'd0);
   assign dec_en      = wb_valid && (wb_wsel != 5'd0) && (cnt_wb != '0);

   // Each counter sees at most one increment and one decrement; both together cancel.
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
         logic inc, dec;
         assign inc = inc_en && (issue_wsel == 5'(gi));
         assign dec = dec_en && (wb_wsel == 5'(gi));
         always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (flush) begin
               cnt_d[gi] = '0;
            end else if (inc && !dec) begin
               cnt_d[gi] = cnt_q[gi] + ONE;
            end else if (dec && !inc) begin
               cnt_d[gi] = cnt_q[gi] - ONE;
            end
         end
         assign busy_d[gi] = (cnt_d[gi] != '0);
      end
   endgenerate

   assign busy_d[0] = 1'b0;

   always_comb begin
      outstanding_d = '0;
      for (int r = 1; r < 32; r++) begin
         outstanding_d = outstanding_d + (CNT_W+5)'(cnt_d[r]);
      end
   end

   assign wb_err_d = wb_err_q || (wb_valid && (wb_wsel != 5'd0) && (cnt_wb == '0));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int r = 1; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q        <= '0;
         outstanding_q <= '0;
         wb_err_q      <= 1'b0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_q        <= busy_d;
         outstanding_q <= outstanding_d;
         wb_err_q      <= wb_err_d;
      end
   end

   assign busy        = busy_q;
   assign outstanding = outstanding_q;
   assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard (CNT_W=2).
module tb_register_scoreboard;

   logic        CLK = 1'b0;
   logic        nRST = 1'b1;
   logic        issue_valid = 1'b0;
   logic        issue_wen = 1'b0;
   logic [4:0]  issue_wsel = '0;
   logic [4:0]  issue_rsel1 = '0;
   logic [4:0]  issue_rsel2 = '0;
   logic        issue_stall;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_wsel = '0;
   logic        flush = 1'b0;
   logic [31:0] busy;
   logic [6:0]  outstanding;
   logic        wb_err;

   int checks = 0;
   int errors = 0;

   register_scoreboard #(.CNT_W(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_wsel(issue_wsel),
      .issue_rsel1(issue_rsel1), .issue_rsel2(issue_rsel2), .issue_stall(issue_stall),
      .wb_valid(wb_valid), .wb_wsel(wb_wsel), .flush(flush),
      .busy(busy), .outstanding(outstanding), .wb_err(wb_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic v, input logic wen, input logic [4:0] w,
                        input logic [4:0] r1, input logic [4:0] r2);
      issue_valid = v;
      issue_wen   = wen;
      issue_wsel  = w;
      issue_rsel1 = r1;
      issue_rsel2 = r2;
   endtask

   task automatic wb(input logic v, input logic [4:0] w);
      wb_valid = v;
      wb_wsel  = w;
   endtask

   initial begin
      // Asynchronous reset before any clock edge
      #1 nRST = 1'b0;
      #1;
      chk("rst_busy", busy, 32'h0);
      chk("rst_outstanding", 32'(outstanding), 32'h0);
      chk("rst_wb_err", 32'(wb_err), 32'h0);
      #7 nRST = 1'b1;
      tick();

      // Scenario 3: register 0 traffic is ignored
      issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      wb(1'b1, 5'd0);
      #1 chk("s3_stall", 32'(issue_stall), 32'h0);
      tick(); tick(); tick();
      chk("s3_busy", busy, 32'h0);
      chk("s3_outstanding", 32'(outstanding), 32'h0);
      chk("s3_wb_err", 32'(wb_err), 32'h0);

      // Scenario 1: RAW stall on r5
      issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
      wb(1'b0, 5'd0);
      #1 chk("s1_first_stall", 32'(issue_stall), 32'h0);
      tick();
      issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
      #1 chk("s1_raw_stall", 32'(issue_stall), 32'h1);
      chk("s1_busy", busy, 32'h0000_0020);
      chk("s1_outstanding", 32'(outstanding), 32'h1);
      issue(1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
      #1 chk("s1_novalid_stall", 32'(issue_stall), 32'h0);

      // Scenario 2: writeback to r5 while reading it as source 2
      issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd5);
      wb(1'b1, 5'd5);
`ifdef SCOREBOARD_BYPASS_EN
      #1 chk("s2_stall", 32'(issue_stall), 32'h0);
`else
      #1 chk("s2_stall", 32'(issue_stall), 32'h1);
`endif
      tick();
      issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      wb(1'b0, 5'd0);
      #1 chk("s2_busy", busy, 32'h0);
      chk("s2_outstanding", 32'(outstanding), 32'h0);
      chk("s2_wb_err", 32'(wb_err), 32'h0);

      // Scenario 4: saturation of r7 at MAXP=3
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
         #1 chk($sformatf("s4_issue%0d_stall", i), 32'(issue_stall), 32'h0);
         tick();
      end
      chk("s4_outstanding3", 32'(outstanding), 32'h3);
      chk("s4_busy", busy, 32'h0000_0080);
      #1 chk("s4_full_stall", 32'(issue_stall), 32'h1);
      tick();
      chk("s4_held_at_max", 32'(outstanding), 32'h3);
      issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      wb(1'b1, 5'd7);
      tick();
      chk("s4_outstanding2", 32'(outstanding), 32'h2);
      issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
      #1 chk("s4_same_stall", 32'(issue_stall), 32'h0);
      tick();
      chk("s4_same_cancel", 32'(outstanding), 32'h2);
      chk("s4_same_busy", busy, 32'h0000_0080);
      issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick(); tick();
      wb(1'b0, 5'd0);
      chk("s4_drained", 32'(outstanding), 32'h0);
      chk("s4_no_err", 32'(wb_err), 32'h0);

      // Scenario 5: orphan writeback sets sticky error
      wb(1'b1, 5'd9);
      tick();
      wb(1'b0, 5'd0);
      chk("s5_err_set", 32'(wb_err), 32'h1);
      chk("s5_outstanding", 32'(outstanding), 32'h0);
      tick(); tick();
      chk("s5_err_sticky", 32'(wb_err), 32'h1);

      // Scenario 6: flush beats a same-cycle accept
      for (int i = 1; i <= 4; i++) begin
         issue(1'b1, 1'b1, 5'(i), 5'd0, 5'd0);
         tick();
      end
      chk("s6_outstanding4", 32'(outstanding), 32'h4);
      chk("s6_busy", busy, 32'h0000_001E);
      issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
      flush = 1'b1;
      #1 chk("s6_flush_stall", 32'(issue_stall), 32'h0);
      tick();
      flush = 1'b0;
      issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("s6_flush_outstanding", 32'(outstanding), 32'h0);
      chk("s6_flush_busy", busy, 32'h0);

      // Mid-stream asynchronous reset
      issue(1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
      tick();
      issue(1'b1, 1'b0, 5'd0, 5'd6, 5'd0);
      #1 chk("rst2_pre_stall", 32'(issue_stall), 32'h1);
      chk("rst2_pre_outstanding", 32'(outstanding), 32'h1);
      #1 nRST = 1'b0;
      #1;
      chk("rst2_busy", busy, 32'h0);
      chk("rst2_outstanding", 32'(outstanding), 32'h0);
      chk("rst2_wb_err", 32'(wb_err), 32'h0);
      chk("rst2_stall", 32'(issue_stall), 32'h0);
      nRST = 1'b1;
      issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      chk("post_rst_outstanding", 32'(outstanding), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
